// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low common-anode 7-segment bus
// and assembles them into a display word with per-frame completion and error flags.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    illegal,
  output logic [IW-1:0]           err_digit,
  output logic                    frame_valid,
  output logic                    frame_error
);

  // Returns {legal, nibble}; anything outside the glyph table is illegal.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    prev_act;
  logic [IW-1:0]           prev_idx;
  logic [6:0]              prev_seg;
  logic [CW-1:0]           cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic                    err_flag;

  logic [NUM_DIGITS-1:0]   sel;
  logic                    active;
  logic [IW-1:0]           idx;
  logic                    match;
  logic [CW-1:0]           cnt_next;
  logic                    accept;
  logic [4:0]              dec;
  logic [4*NUM_DIGITS-1:0] value_next;
  logic [NUM_DIGITS-1:0]   dv_next;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    ill_now;
  logic                    frame_done;

  always_comb begin
    sel    = ~an_r;
    active = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) idx = IW'(i);
    end
    match = prev_act && (prev_idx == idx) && (prev_seg == seg_r);

    if (!active)
      cnt_next = '0;
    else if (match)
      cnt_next = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
    else
      cnt_next = CW'(1);

    // A saturated, unchanged dwell must not fire again.
    accept = active && (cnt_next == CW'(STABLE_CYCLES)) &&
             !(match && (cnt == CW'(STABLE_CYCLES)));

    dec        = decode(seg_r);
    value_next = value;
    dv_next    = digit_valid;
    seen_next  = seen;
    ill_now    = 1'b0;
    if (accept) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) begin
          seen_next[i] = 1'b1;
          dv_next[i]   = dec[4];
          if (dec[4]) value_next[4*i +: 4] = dec[3:0];
        end
      end
      ill_now = !dec[4];
    end
    frame_done = accept && (&seen_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r        <= '1;
      seg_r       <= 7'h7F;
      prev_act    <= 1'b0;
      prev_idx    <= '0;
      prev_seg    <= 7'h7F;
      cnt         <= '0;
      seen        <= '0;
      err_flag    <= 1'b0;
      value       <= '0;
      digit_valid <= '0;
      illegal     <= 1'b0;
      err_digit   <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      an_r        <= an_n;
      seg_r       <= seg_n;
      prev_act    <= active;
      prev_idx    <= idx;
      prev_seg    <= seg_r;
      cnt         <= cnt_next;
      value       <= value_next;
      digit_valid <= dv_next;
      illegal     <= ill_now;
      if (ill_now) err_digit <= idx;
      frame_valid <= frame_done;
      frame_error <= frame_done && (err_flag || ill_now);
      if (frame_done) begin
        seen     <= '0;
        err_flag <= 1'b0;
      end else begin
        seen     <= seen_next;
        err_flag <= err_flag || ill_now;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: a run-length model of the scanned bus predicts
// every output each cycle; directed scenarios add literal checks on top.
module tb_seven_seg_scan_decoder;
  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_valid;
  logic          illegal;
  logic [1:0]    err_digit;
  logic          frame_valid;
  logic          frame_error;

  seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .an_n(an_n), .seg_n(seg_n),
    .value(value), .digit_valid(digit_valid), .illegal(illegal),
    .err_digit(err_digit), .frame_valid(frame_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_seen, ill_seen;
  logic last_fe;

  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: last captured sample and how many identical samples in a row.
  logic [ND-1:0]   cap_an;
  logic [6:0]      cap_seg;
  int              run_len;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_dv, m_seen;
  logic            m_ill, m_fv, m_fe, m_eflag;
  int              m_err;

  function automatic int active_idx(input logic [ND-1:0] a);
    int lows = 0;
    int pos = -1;
    for (int i = 0; i < ND; i++) if (!a[i]) begin lows++; pos = i; end
    return (lows == 1) ? pos : -1;
  endfunction

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (pat_tab[k] == s) return k;
    return -1;
  endfunction

  task automatic model_reset();
    cap_an = '1; cap_seg = 7'h7F; run_len = 0;
    m_value = '0; m_dv = '0; m_seen = '0;
    m_ill = 0; m_fv = 0; m_fe = 0; m_eflag = 0; m_err = 0;
  endtask

  task automatic model_step();
    int ci, ni, nib;
    m_ill = 0; m_fv = 0; m_fe = 0;
    ci = active_idx(cap_an);
    if (ci >= 0 && run_len == S) begin
      nib = lookup(cap_seg);
      if (nib >= 0) begin
        m_value[4*ci +: 4] = 4'(nib);
        m_dv[ci] = 1'b1;
      end else begin
        m_dv[ci] = 1'b0;
        m_ill = 1; m_err = ci; m_eflag = 1;
      end
      m_seen[ci] = 1'b1;
      if (&m_seen) begin
        m_fv = 1; m_fe = m_eflag; m_seen = '0; m_eflag = 0;
      end
    end
    ni = active_idx(an_n);
    if (ni < 0) run_len = 0;
    else if (ci == ni && cap_seg == seg_n) run_len++;
    else run_len = 1;
    cap_an = an_n; cap_seg = seg_n;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the rising edge, DUT compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    check("value", 32'(value), 32'(m_value));
    check("digit_valid", 32'(digit_valid), 32'(m_dv));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("err_digit", 32'(err_digit), 32'(m_err));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_error", 32'(frame_error), 32'(m_fe));
    if (frame_valid) begin fv_seen++; last_fe = frame_error; end
    if (illegal) ill_seen++;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int cycles);
    an_n = ~(ND'(1) << d);
    seg_n = s;
    repeat (cycles) tick();
  endtask

  task automatic idle(input int cycles);
    an_n = '1; seg_n = 7'h7F;
    repeat (cycles) tick();
  endtask

  task automatic clear_counts();
    fv_seen = 0; ill_seen = 0; last_fe = 1'bx;
  endtask

  initial begin
    reset = 1'b1; an_n = '1; seg_n = 7'h7F;
    model_reset();
    clear_counts();
    repeat (2) tick();
    check("rst_value", 32'(value), 32'h0);
    check("rst_dv", 32'(digit_valid), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    reset = 1'b0;
    idle(2);

    // Legal frame 1,2,3,4
    clear_counts();
    show(0, 7'h79, 8); show(1, 7'h24, 8); show(2, 7'h30, 8); show(3, 7'h19, 8);
    idle(2);
    check("legal_value", 32'(value), 32'h4321);
    check("legal_dv", 32'(digit_valid), 32'hF);
    check("legal_fv_count", fv_seen, 1);
    check("legal_fe", 32'(last_fe), 32'h0);

    // Short dwell: 3 cycles rejected, 4 cycles accepted on the 5th edge
    show(2, 7'h12, 3); show(3, 7'h19, 8);
    check("short3_nib2", 32'(value[11:8]), 32'h3);
    show(2, 7'h12, 4);
    an_n = '1; seg_n = 7'h7F;
    tick();
    check("short4_nib2", 32'(value[11:8]), 32'h5);
    idle(2);

    // Illegal blank on digit 1 completes a frame with error
    clear_counts();
    show(0, 7'h79, 8); show(1, 7'h7F, 6);
    idle(2);
    check("ill_count", ill_seen, 1);
    check("ill_err_digit", 32'(err_digit), 32'h1);
    check("ill_dv1", 32'(digit_valid[1]), 32'h0);
    check("ill_value", 32'(value), 32'h4521);
    check("ill_fv_count", fv_seen, 1);
    check("ill_fe", 32'(last_fe), 32'h1);

    // Ghosting: two anodes low
    clear_counts();
    an_n = 4'b1100; seg_n = 7'h40;
    repeat (10) tick();
    idle(2);
    check("ghost_pulses", fv_seen + ill_seen, 0);
    check("ghost_value", 32'(value), 32'h4521);

    // Long dwell
    clear_counts();
    show(0, 7'h0E, 50);
    idle(2);
    check("long_nib0", 32'(value[3:0]), 32'hF);
    check("long_pulses", fv_seen + ill_seen, 0);

    // Randomized scanning
    for (int it = 0; it < 400; it++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode < 8) an_n = ~(ND'(1) << $urandom_range(0, ND - 1));
      else if (mode == 8) an_n = '1;
      else an_n = ND'($urandom_range(0, (1 << ND) - 1));
      if ($urandom_range(0, 3) != 0) seg_n = pat_tab[$urandom_range(0, 15)];
      else seg_n = 7'($urandom_range(0, 127));
      repeat ($urandom_range(1, 8)) tick();
    end

    // Async reset mid-frame
    reset = 1'b1; model_reset(); idle(2); reset = 1'b0; idle(1);
    show(0, 7'h79, 8); show(1, 7'h24, 8); show(2, 7'h30, 8);
    #2 reset = 1'b1;
    #1;
    check("arst_value", 32'(value), 32'h0);
    check("arst_dv", 32'(digit_valid), 32'h0);
    check("arst_ill", 32'(illegal), 32'h0);
    check("arst_err", 32'(err_digit), 32'h0);
    check("arst_fv", 32'(frame_valid), 32'h0);
    check("arst_fe", 32'(frame_error), 32'h0);
    model_reset();
    idle(2);
    reset = 1'b0;
    clear_counts();
    show(3, 7'h19, 8);
    idle(2);
    check("arst_no_frame", fv_seen, 0);
    check("arst_partial_value", 32'(value), 32'h4000);
    show(0, 7'h79, 8); show(1, 7'h24, 8); show(2, 7'h30, 8);
    idle(2);
    check("arst_full_frame", fv_seen, 1);
    check("arst_full_fe", 32'(last_fe), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
